uart_rx_mmio: RTL
=================

// Module: uart_rx_mmio
// PURPOSE
//  8N1 serial receiver: the receive-side counterpart of the CPU's memory-mapped UART transmitter.
//  Oversamples the uart_rx pin and buffers received bytes in a small FIFO.
//  The core pops bytes with a load from the UART RX data address; the memory-access stage decodes
//  the address and drives rd_en. Status is read from a separate MMIO status address.
// PARAMETERS
//  CLK_HZ      125_000_000  system clock frequency
//  BAUD        115200       line rate; DIV = CLK_HZ/BAUD (integer divide), HALF = DIV/2
//  FIFO_DEPTH  4            receive FIFO entries; power of two, >= 2
// PORTS
//  clk         in   1   system clock; single clock domain
//  nrst        in   1   asynchronous, active-low reset
//  uart_rx     in   1   serial input, asynchronous to clk; idles high
//  rd_en       in   1   pop strobe, one cycle per load from the RX data address
//  err_clr     in   1   clears all sticky error flags
//  rd_data     out  8   FIFO head (show-ahead); 0 when FIFO is empty
//  rx_valid    out  1   FIFO not empty
//  rx_count    out  $clog2(FIFO_DEPTH)+1   number of bytes held in the FIFO
//  rx_busy     out  1   FSM is not IDLE
//  frame_err   out  1   sticky: a stop bit was sampled low
//  overrun     out  1   sticky: a byte arrived while the FIFO was full
//  parity_err  out  1   sticky: parity mismatch; tied 0 unless UART_RX_PARITY_EN is defined
// BEHAVIOUR
//  Reset: every register is cleared immediately, including mid-frame. All outputs are 0 and the
//   synchronizer flops are set to 1.
//  Sync: two-flop synchronizer on uart_rx. The FSM sees only rx_s (two cycles of latency).
//  Timing: one down-counter. "Tick" means the counter has reached 0; the counter reloads on each tick.
//  FSM states and transitions:
//   IDLE  : rx_s==0 -> START, counter = HALF-1.
//   START : on tick, rx_s==0 -> DATA, counter = DIV-1, bit index = 0;
//           rx_s==1 -> IDLE (glitch rejected, nothing is recorded).
//   DATA  : on each tick, shift rx_s in LSB-first. After bit 7 -> STOP, or PARITY when the
//           macro is defined.
//   PARITY: on tick, compare rx_s with the XOR of the data bits (even parity). On mismatch set
//           parity_err; the byte is still kept. Then -> STOP.
//   STOP  : on tick, rx_s==1 -> push the byte, -> IDLE.
//           rx_s==0 -> set frame_err, discard the byte, -> BRK.
//   BRK   : wait for rx_s==1, then -> IDLE. This prevents retriggering during a break.
//  Push latency: the byte is visible on rd_data/rx_valid the cycle after the stop-bit tick.
//  FIFO behaviour:
//   Push while full and no pop: byte is dropped and overrun is set.
//   Push and pop in the same cycle while full: both take effect; no overrun; count is unchanged.
//   rd_en while empty: ignored. A simultaneous push still stores its byte.
//   Pointers wrap modulo FIFO_DEPTH.
//  err_clr: clears all three flags. If a set event occurs in the same cycle, the set wins.
// CONFIGURATION
//  UART_RX_PARITY_EN defined: frame is 8E1, adding the PARITY state; parity_err is live.
//  UART_RX_PARITY_EN undefined: frame is 8N1, no PARITY state; parity_err is constant 0.
// STRUCTURE
//  Shared defines file: UART_RX_DATA_ADDR and UART_RX_STAT_ADDR (next to UART_ADDR), plus the
//   status-word bit positions {parity_err, overrun, frame_err, rx_busy, rx_valid}.
//  FSM state encodings stay local to this module.
//  Sub-module uart_rx_fifo: parameterised synchronous show-ahead FIFO with ports push, pop,
//   din, dout, count, full, empty.
// TESTING  (bench uses CLK_HZ=8, BAUD=1 -> DIV=8, HALF=4)
//  1. Send 0xA5 with a valid stop bit -> cycle after the stop tick: rx_valid=1, rd_data=0xA5,
//     rx_count=1; one rd_en pulse -> rx_valid=0, rd_data=0.
//  2. Drive uart_rx low for 3 clocks, then high -> rx_busy pulses, then IDLE; rx_count stays 0;
//     no flags are set.
//  3. Send 0x01..0x05 back-to-back with no reads -> rx_count=4, overrun=1; four reads return
//     0x01..0x04; a fifth rd_en is ignored.
//  4. Send 0x3C with the stop bit low, then hold the line low for 20 clocks -> frame_err=1,
//     rx_count=0, FSM held in BRK; release the line and pulse err_clr -> frame_err=0; next 0x11
//     is received correctly.
//  5. Assert nrst low after data bit 3 of 0x7E -> all outputs 0 immediately; release reset and
//     resend 0x7E -> rd_data=0x7E.
//  6. With UART_RX_PARITY_EN: send 0x03 with parity bit 1 -> parity_err=1, rd_data=0x03;
//     send 0x03 with parity bit 0 -> parity_err stays 1 until err_clr.

Source files
------------

// File: rtl/uart_rx_mmio_pkg.sv
// Shared UART receive definitions: MMIO addresses, status-word bit positions, width helper.
// Optional 8E1 framing is enabled by defining UART_RX_PARITY_EN.
package uart_rx_mmio_pkg;

    localparam logic [31:0] UART_ADDR         = 32'h0000_4000;
    localparam logic [31:0] UART_RX_DATA_ADDR = 32'h0000_4004;
    localparam logic [31:0] UART_RX_STAT_ADDR = 32'h0000_4008;

    // Bit positions inside the word returned from UART_RX_STAT_ADDR.
    localparam int STAT_RX_VALID   = 0;
    localparam int STAT_RX_BUSY    = 1;
    localparam int STAT_FRAME_ERR  = 2;
    localparam int STAT_OVERRUN    = 3;
    localparam int STAT_PARITY_ERR = 4;
    localparam int STAT_W          = 5;

    function automatic int width_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous show-ahead FIFO: dout always presents the head entry.
// A pop on an empty FIFO is ignored; a push while full is accepted only alongside a pop.
module uart_rx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     nrst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   cnt;
    logic             do_push;
    logic             do_pop;

    assign empty   = (cnt == '0);
    assign full    = (cnt == (PTR_W+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr];
    assign count   = cnt;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            // NOTE: storage is cleared too so a reset leaves no stale byte anywhere in the block.
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_mmio.sv
// Oversampling serial receiver feeding a show-ahead FIFO popped by MMIO loads.
// Frame is 8N1 by default; defining UART_RX_PARITY_EN switches to 8E1 with a live parity_err.
module uart_rx_mmio
    import uart_rx_mmio_pkg::*;
#(
    parameter int CLK_HZ     = 125_000_000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          nrst,
    input  logic                          uart_rx,
    input  logic                          rd_en,
    input  logic                          err_clr,
    output logic [7:0]                    rd_data,
    output logic                          rx_valid,
    output logic [$clog2(FIFO_DEPTH):0]   rx_count,
    output logic                          rx_busy,
    output logic                          frame_err,
    output logic                          overrun,
    output logic                          parity_err
);

    localparam int DIV   = CLK_HZ / BAUD;
    localparam int HALF  = DIV / 2;
    localparam int CNT_W = width_of(DIV);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BRK
    } state_t;

    logic             rx_meta, rx_s;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shreg_q, shreg_d;
    logic             tick;
    logic             push, frame_set, overrun_set;
    logic             frame_err_q, overrun_q;
    logic [7:0]       fifo_dout;
    logic             fifo_full, fifo_empty;

    // The line idles high, so the synchronizer resets to 1 to avoid a false start bit.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments make the two flops a real two-stage chain.
            rx_meta <= uart_rx;
            rx_s    <= rx_meta;
        end
    end

    assign tick = (cnt_q == '0);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
        end
    end

`ifdef UART_RX_PARITY_EN
    logic parity_set;
    logic parity_err_q;
`endif

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d   = state_q;
        cnt_d     = tick ? CNT_W'(DIV - 1) : cnt_q - 1'b1;
        bit_d     = bit_q;
        shreg_d   = shreg_q;
        push      = 1'b0;
        frame_set = 1'b0;
`ifdef UART_RX_PARITY_EN
        parity_set = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (!rx_s) begin
                    state_d = S_START;
                    cnt_d   = CNT_W'(HALF - 1);
                end
            end
            S_START: begin
                if (tick) begin
                    if (!rx_s) begin
                        state_d = S_DATA;
                        bit_d   = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_DATA: begin
                if (tick) begin
                    shreg_d = {rx_s, shreg_q[7:1]};
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (tick) begin
                    parity_set = (rx_s != ^shreg_q);
                    state_d    = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (tick) begin
                    if (rx_s) begin
                        push    = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        frame_set = 1'b1;
                        state_d   = S_BRK;
                    end
                end
            end
            // Hold off until the line returns high so a long break yields one error, not many.
            S_BRK: begin
                if (rx_s) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (clk),
        .nrst  (nrst),
        .push  (push),
        .pop   (rd_en),
        .din   (shreg_q),
        .dout  (fifo_dout),
        .count (rx_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // A pop in the same cycle makes room, so only an unpaired push into a full FIFO is lost.
    assign overrun_set = push & fifo_full & ~rd_en;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            frame_err_q <= frame_set   | (frame_err_q & ~err_clr);
            overrun_q   <= overrun_set | (overrun_q   & ~err_clr);
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) parity_err_q <= 1'b0;
        else       parity_err_q <= parity_set | (parity_err_q & ~err_clr);
    end
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

    assign rd_data   = fifo_empty ? 8'h00 : fifo_dout;
    assign rx_valid  = ~fifo_empty;
    assign rx_busy   = (state_q != S_IDLE);
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule
